// File: rtl/mul_seq_su.sv
// mul_seq_su: iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU).
// Shift-add on operand magnitudes, RADIX_BITS multiplier bits per CALC cycle,
// then one SIGN cycle that negates the 2*XLEN product if needed and selects
// the requested half.
// Optional build macro: MUL_EARLY_OUT_EN -- leave CALC as soon as the
// remaining multiplier bits or the multiplicand are zero. Default build
// (macro undefined) has a fixed XLEN/RADIX_BITS+2 cycle latency.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | shift-add loop, count steps remaining
// SIGN  | apply sign fix, capture result half
// DONE  | result valid, waiting for out_ready
module mul_seq_su #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int STEPS = XLEN / RADIX_BITS;
  localparam int CW    = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [1:0]          op_q;
  logic                sa_q;
  logic                sb_q;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       count;
  logic [XLEN-1:0]     result_q;

  logic                sa_in;
  logic                sb_in;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic [RADIX_BITS-1:0] digit;
  logic [2*XLEN-1:0]   partial;
  logic [2*XLEN-1:0]   acc_sum;
  logic [2*XLEN-1:0]   acc_fix;
  logic [XLEN-1:0]     mplier_rest;

  // Operand signs and magnitudes at accept time; -2^(XLEN-1) maps to
  // 2^(XLEN-1), which fits as an unsigned XLEN-bit value.
  always_comb begin
    sa_in = a[XLEN-1] & ((op == 2'b01) | (op == 2'b10));
    sb_in = b[XLEN-1] & (op == 2'b01);
    abs_a = sa_in ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
    abs_b = sb_in ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;
  end

  // One radix step of the shift-add loop plus the final sign fix.
  // The multiplicand register is pre-shifted, so no separate shift count
  // is needed; it never loses bits inside 2*XLEN.
  always_comb begin
    digit       = mplier[RADIX_BITS-1:0];
    partial     = mcand * {{(2*XLEN-RADIX_BITS){1'b0}}, digit};
    acc_sum     = acc + partial;
    mplier_rest = mplier >> RADIX_BITS;
    acc_fix     = (sa_q ^ sb_q) ? (~acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; kill overrides every transition, including accept.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = CALC;
      CALC: begin
        if (count == CW'(1)) next_state = SIGN;
`ifdef MUL_EARLY_OUT_EN
        else if ((mplier_rest == '0) || (mcand == '0)) next_state = SIGN;
`endif
      end
      SIGN: next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (kill) next_state = IDLE;
  end

  // Datapath registers; a killed cycle leaves everything, including the
  // result register, untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
    end else if (!kill) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            mcand  <= {{XLEN{1'b0}}, abs_a};
            mplier <= abs_b;
            acc    <= '0;
            count  <= CW'(STEPS);
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier_rest;
          count  <= count - CW'(1);
        end
        SIGN: begin
          acc      <= acc_fix;
          result_q <= (op_q == 2'b00) ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_mul_seq_su.sv
// tb_mul_seq_su: directed vector table plus hand-written sequences for
// stall, kill, async reset and a 64-bit reference check on pseudo-random ops.
module tb_mul_seq_su;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  mul_seq_su #(.XLEN(32), .RADIX_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present one request, scramble operands right after accept, and wait
  // (bounded) for out_valid. lat counts edges after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output logic ok);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin ok = 1'b1; break; end
    end
    res = result;
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ax, by, p;
    logic sx, sy;
    sx = x[31] & ((o == 2'b01) | (o == 2'b10));
    sy = y[31] & (o == 2'b01);
    ax = {{32{sx}}, x};
    by = {{32{sy}}, y};
    p  = ax * by;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    int          lat;
    logic        ok;
    logic        seen;

    vecs[0]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[2]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[4]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[6]  = '{2'b10, 32'h80000000, 32'h80000000, 32'hC0000000};
    vecs[7]  = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[8]  = '{2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E};
    vecs[9]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[10] = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[11] = '{2'b11, 32'h00000007, 32'hFFFFFFFD, 32'h00000006};
    vecs[12] = '{2'b10, 32'h00000007, 32'hFFFFFFFD, 32'h00000006};
    vecs[13] = '{2'b10, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF};
    vecs[14] = '{2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000};
    vecs[15] = '{2'b00, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};

    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; b = '0;
    #12;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table, result consumed immediately.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, ok);
      chk($sformatf("vec%0d done", i), {31'b0, ok}, 32'd1);
      chk($sformatf("vec%0d result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), lat, 32'd17);
      @(posedge clk); #1;
      chk($sformatf("vec%0d consumed", i), {31'b0, in_ready}, 32'd1);
    end

    // Back-pressure: result and out_valid held while out_ready low.
    out_ready = 1'b0;
    run_op(2'b11, 32'h12345678, 32'h9ABCDEF0, res, lat, ok);
    chk("stall done", {31'b0, ok}, 32'd1);
    chk("stall latency", lat, 32'd17);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall result", result, 32'h0B00EA4E);
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall release in_ready", {31'b0, in_ready}, 32'd1);
    chk("stall release out_valid", {31'b0, out_valid}, 32'd0);

    // Kill in the 5th CALC cycle.
    op = 2'b11; a = 32'h12345678; b = 32'h9ABCDEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill calc in_ready", {31'b0, in_ready}, 32'd1);
    chk("kill calc busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("kill calc no out_valid", {31'b0, seen}, 32'd0);
    chk("kill calc result kept", result, 32'h0B00EA4E);
    run_op(2'b00, 32'd7, 32'hFFFFFFFD, res, lat, ok);
    chk("after kill done", {31'b0, ok}, 32'd1);
    chk("after kill result", res, 32'hFFFFFFEB);
    @(posedge clk); #1;

    // Kill in IDLE beats in_valid.
    in_valid = 1'b1; kill = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill idle busy", {31'b0, busy}, 32'd0);
    chk("kill idle in_ready", {31'b0, in_ready}, 32'd1);

    // Kill alone in DONE: valid drops, result register unchanged.
    out_ready = 1'b0;
    run_op(2'b11, 32'd7, 32'hFFFFFFFD, res, lat, ok);
    chk("kill done setup", res, 32'h00000006);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill done out_valid", {31'b0, out_valid}, 32'd0);
    chk("kill done in_ready", {31'b0, in_ready}, 32'd1);
    chk("kill done result", result, 32'h00000006);

    // Kill together with out_ready in DONE.
    run_op(2'b01, 32'h80000000, 32'h80000000, res, lat, ok);
    chk("kill+ready setup", res, 32'h40000000);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill+ready in_ready", {31'b0, in_ready}, 32'd1);
    chk("kill+ready out_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset mid-CALC.
    op = 2'b00; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("async rst busy", {31'b0, busy}, 32'd0);
    chk("async rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("async rst result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(2'b01, 32'h80000000, 32'h80000000, res, lat, ok);
    chk("post rst done", {31'b0, ok}, 32'd1);
    chk("post rst result", res, 32'h40000000);
    chk("post rst latency", lat, 32'd17);
    @(posedge clk); #1;

    // Pseudo-random ops against a 64-bit reference product.
    for (int i = 0; i < 40; i++) begin
      ro = 2'(i % 4);
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 3) ra = 32'h80000000;
      if (i % 10 == 7) rb = 32'h80000000;
      run_op(ro, ra, rb, res, lat, ok);
      chk($sformatf("rand%0d op%0d %h*%h", i, ro, ra, rb), res, ref_mul(ro, ra, rb));
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_seq_su.md
# mul_seq_su

Iterative, parametrised multiplier for the RV32M execute stage. It implements all four RISC-V multiply variants: MUL, MULH, MULHSU and MULHU. Operands are taken over a valid/ready handshake, and the product is formed by a radix-2^RADIX_BITS shift-add loop on magnitudes followed by a sign-fix cycle. The selected XLEN-bit half of the 2·XLEN product is returned. A kill input lets the interrupt/flush logic abandon an in-flight operation.

## Interface
- XLEN, 32: operand and result width; must be a multiple of RADIX_BITS.
- RADIX_BITS, 2: multiplier bits retired per CALC cycle; legal values 1, 2, 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request; high only in IDLE.
- op  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- a  in  XLEN  rs1 operand; signed for MULH and MULHSU.
- b  in  XLEN  rs2 operand; signed for MULH only.
- kill  in  1  abort any in-flight operation.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  selected product half.
- busy  out  1  high in CALC, SIGN and DONE.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid, latch op and compute the operand signs: sa = a[XLEN-1] & (op==01 | op==10); sb = b[XLEN-1] & (op==01).
  - Latch magnitudes |a|, |b| as XLEN-bit unsigned. The most negative value maps to 2^(XLEN-1), with no overflow.
  - Clear the 2·XLEN accumulator, load count = XLEN/RADIX_BITS, then go to CALC.
- **CALC:**
  - Each cycle: acc += (|a| × low RADIX_BITS of the multiplier) << shift.
  - The multiplier shifts right by RADIX_BITS and count decrements.
  - When count reaches 1, go to SIGN on the next edge.
- **SIGN:**
  - If sa^sb, acc = two's-complement negation of acc over 2·XLEN bits.
  - result register = acc[XLEN-1:0] for op 00, otherwise acc[2·XLEN-1:XLEN].
  - Go to DONE.
- **DONE:**
  - out_valid=1 and result stable.
  - On out_ready, go to IDLE on the same edge.
  - A new request is not accepted in the same cycle (in_ready=0 in DONE).
- **kill:** in any state, kill forces IDLE at the next edge, out_valid=0, and the result register is unchanged.
  - kill in IDLE with in_valid=1 wins: the request is not accepted.
  - kill and out_ready in DONE together: the result is considered consumed; the state is IDLE either way.
- **Arithmetic:** all products are exact modulo 2^(2·XLEN). In particular, MUL is independent of signedness.
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, acc=0, count=0.

## Timing
- Request accepted at edge E (in_valid & in_ready).
- CALC occupies edges E+1 … E+XLEN/RADIX_BITS.
- SIGN occupies the next edge; out_valid is first high after edge E+XLEN/RADIX_BITS+1.
- Defaults give 16 CALC cycles, so out_valid is high in cycle 18 counting the accept cycle as 1.
- Throughput is one op per XLEN/RADIX_BITS+3 cycles when out_ready is held high.
- Operand inputs are sampled only at accept; changes afterwards have no effect.
- rst mid-operation returns immediately to reset values; no output glitches high.

## Configuration
- **MUL_EARLY_OUT_EN defined:**
  - In CALC, if the remaining multiplier bits are all zero, or |a| is zero, skip directly to SIGN on the next edge.
  - Minimum latency: out_valid is high after edge E+2 (b=0 or a=0).
  - Results are bit-identical to the non-early-out build.
- **MUL_EARLY_OUT_EN undefined:** latency is always fixed as stated under Timing. This is the default build for the cycle-deterministic interrupt path.

## Test plan
- MULHSU, a=0xFFFFFFFF (−1), b=0xFFFFFFFF, out_ready=1 -> result=0xFFFFFFFF; same operands with MUL -> 0x00000001; with MULHU -> 0xFFFFFFFE.
- MULH, a=0x80000000, b=0x80000000 -> result=0x40000000; MUL -> 0x00000000; MULHSU, a=0x80000000, b=0x80000000 -> 0xC0000000.
- Defaults, no early-out: MULHU 0x12345678×0x9ABCDEF0 accepted at edge 0 -> out_valid first high after edge 17, result=0x0B00EA4E; out_ready held low 5 cycles -> result and out_valid stable, in_ready=0 throughout.
- kill asserted on the 5th CALC cycle -> IDLE next edge, out_valid never asserted. A following MUL 7×(−3) -> 0xFFFFFFEB.
- rst pulsed asynchronously mid-CALC -> outputs at reset values before the next clock edge; the next request completes normally.
- Randomised 10k ops per op code, RADIX_BITS ∈ {1,2,4}, compared against a 64-bit reference product. With MUL_EARLY_OUT_EN, MULH a=5, b=0 -> out_valid after edge 2, result=0.
